// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/bubble constants,
// request FSM state encoding and the fetch-queue entry layout.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_BUSY = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    // Word-align an address; misaligned redirect targets are silently fixed.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: one-outstanding req/ack handshake.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, inst} pairs; flush beats push and pop.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fq_entry_t                push_data,
    output fq_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    fq_entry_t         mem_r [QDEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              do_push_s;
    logic              do_pop_s;

    // Qualify requests: a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (!flush) begin
            do_pop_s  = pop & (count_r != {CW{1'b0}});
            do_push_s = push & ((count_r != CW'(QDEPTH)) | do_pop_s);
        end else begin
            do_pop_s  = 1'b0;
            do_push_s = 1'b0;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_r[i] <= '{pc: 32'd0, inst: 32'd0};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(QDEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, one-outstanding memory
// reads into a small queue, and the IF/ID output register with stall/redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                keep,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         PC_pype0,
    output logic [31:0]         PCp4_pype0,
    output logic [31:0]         Instraction_pype,
    output logic                inst_valid
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] SPACE_LIMIT = (CW + 1)'(QDEPTH - 1);

    if_state_e      state_r;
    if_state_e      state_s;
    logic           req_r;
    logic           req_s;
    logic [31:0]    addr_r;
    logic [31:0]    addr_s;
    logic [31:0]    fpc_r;
    logic [31:0]    fpc_s;

    logic           ack_s;
    logic [31:0]    target_s;
    logic           q_push_s;
    logic           q_pop_s;
    logic           q_full_s;
    logic           q_empty_s;
    logic [CW-1:0]  q_count_s;
    fq_entry_t      q_head_s;
    fq_entry_t      q_wdata_s;
    logic [CW:0]    entries_after_s;
    logic           space_s;

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push_s),
        .pop       (q_pop_s),
        .flush     (redirect),
        .push_data (q_wdata_s),
        .head      (q_head_s),
        .full      (q_full_s),
        .empty     (q_empty_s),
        .count     (q_count_s)
    );

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = addr_r;

    // Queue traffic for this edge and whether one more request still fits.
    always_comb begin
        ack_s           = imem.imem_ack & req_r;
        target_s        = align_pc(redirect_pc);
        q_wdata_s       = '{pc: addr_r, inst: imem.imem_rdata};
        q_push_s        = 1'b0;
        q_pop_s         = 1'b0;
        entries_after_s = {(CW + 1){1'b0}};
        if (redirect) begin
            q_push_s        = 1'b0;
            q_pop_s         = 1'b0;
            entries_after_s = {(CW + 1){1'b0}};
        end else begin
            q_push_s        = (state_r == IF_BUSY) & ack_s;
            q_pop_s         = ~keep & ~q_empty_s;
            entries_after_s = {1'b0, q_count_s}
                            + {{CW{1'b0}}, q_push_s}
                            - {{CW{1'b0}}, q_pop_s};
        end
        space_s = (entries_after_s <= SPACE_LIMIT);
    end

    // Request FSM next state; redirect outranks everything else.
    always_comb begin
        state_s = state_r;
        req_s   = req_r;
        addr_s  = addr_r;
        fpc_s   = fpc_r;
        if (redirect) begin
            if ((state_r != IF_IDLE) && !ack_s) begin
                fpc_s   = target_s;
                state_s = IF_DROP;
            end else begin
                req_s   = 1'b1;
                addr_s  = target_s;
                fpc_s   = target_s + 32'd4;
                state_s = IF_BUSY;
            end
        end else begin
            case (state_r)
                IF_IDLE: begin
                    if (space_s) begin
                        req_s   = 1'b1;
                        addr_s  = fpc_r;
                        fpc_s   = fpc_r + 32'd4;
                        state_s = IF_BUSY;
                    end else begin
                        state_s = IF_IDLE;
                    end
                end
                IF_BUSY: begin
                    if (ack_s && space_s) begin
                        req_s   = 1'b1;
                        addr_s  = fpc_r;
                        fpc_s   = fpc_r + 32'd4;
                        state_s = IF_BUSY;
                    end else if (ack_s) begin
                        req_s   = 1'b0;
                        state_s = IF_IDLE;
                    end else begin
                        state_s = IF_BUSY;
                    end
                end
                IF_DROP: begin
                    // The queue was flushed on entry, so there is always room here.
                    if (ack_s) begin
                        req_s   = 1'b1;
                        addr_s  = fpc_r;
                        fpc_s   = fpc_r + 32'd4;
                        state_s = IF_BUSY;
                    end else begin
                        state_s = IF_DROP;
                    end
                end
                default: begin
                    req_s   = 1'b0;
                    state_s = IF_IDLE;
                end
            endcase
        end
    end

    // Request FSM state, held request and fetch PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IF_IDLE;
            req_r   <= 1'b0;
            addr_r  <= RESET_PC;
            fpc_r   <= RESET_PC;
        end else begin
            state_r <= state_s;
            req_r   <= req_s;
            addr_r  <= addr_s;
            fpc_r   <= fpc_s;
        end
    end

    // IF/ID output register: redirect bubble, stall hold, queue head or bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC_pype0         <= 32'd0;
            PCp4_pype0       <= 32'd0;
            Instraction_pype <= NOP_INST;
            inst_valid       <= 1'b0;
        end else if (redirect) begin
            PC_pype0         <= 32'd0;
            PCp4_pype0       <= 32'd0;
            Instraction_pype <= NOP_INST;
            inst_valid       <= 1'b0;
        end else if (keep) begin
            PC_pype0         <= PC_pype0;
            PCp4_pype0       <= PCp4_pype0;
            Instraction_pype <= Instraction_pype;
            inst_valid       <= inst_valid;
        end else if (!q_empty_s) begin
            PC_pype0         <= q_head_s.pc;
            PCp4_pype0       <= q_head_s.pc + 32'd4;
            Instraction_pype <= q_head_s.inst;
            inst_valid       <= 1'b1;
        end else begin
            PC_pype0         <= 32'd0;
            PCp4_pype0       <= 32'd0;
            Instraction_pype <= NOP_INST;
            inst_valid       <= 1'b0;
        end
    end

endmodule
